axis_frame_capture: RTL and testbench

AXIS_FRAME_CAPTURE -- requirements
Module: axis_frame_capture

---
 rtl/alpaca_ospfb_constants_pkg.sv | 24 ++
 rtl/axis_frame_checker.sv | 42 ++++
 rtl/axis_frame_capture.sv | 155 +++++++++++++++
 tb/tb_axis_frame_capture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and state encoding for the OSPFB frame capture path.
package alpaca_ospfb_constants_pkg;

    localparam int DEF_FRAME_LEN  = 2048;
    localparam int DEF_MAX_FRAMES = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SKIP    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FULL    = 3'd4
    } cap_state_t;

    // A request of zero frames, or more than fit, means "fill the whole buffer".
    function automatic int unsigned clamp_frames(input int unsigned req, input int unsigned max_frames);
        if (req == 32'd0 || req > max_frames) begin
            return max_frames;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/axis_frame_checker.sv
// Per-frame beat counter with sticky tlast framing error flags.
module axis_frame_checker
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic beat,
    input  logic tlast,
    output logic err_tlast_unexpected,
    output logic err_tlast_missing
);

    localparam int            CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_r;

    // Track position within the frame; errors resync the counter so capture keeps going.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r                <= '0;
            err_tlast_unexpected <= 1'b0;
            err_tlast_missing    <= 1'b0;
        end else if (beat) begin
            if (tlast && (cnt_r != LAST_IDX)) begin
                err_tlast_unexpected <= 1'b1;
                cnt_r                <= '0;
            end else if (cnt_r == LAST_IDX) begin
                if (!tlast) begin
                    err_tlast_missing <= 1'b1;
                end
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/axis_frame_capture.sv
// Frame-aligned AXI-Stream capture into a block-RAM buffer with registered readback.
module axis_frame_capture
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int DATA_WID     = 32,
    parameter int FRAME_LEN    = DEF_FRAME_LEN,
    parameter int MAX_FRAMES   = DEF_MAX_FRAMES,
    parameter bit BACKPRESSURE = 1'b0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [DATA_WID-1:0]                      s_axis_tdata,
    input  logic                                     s_axis_tvalid,
    input  logic                                     s_axis_tlast,
    output logic                                     s_axis_tready,
    input  logic                                     arm,
    input  logic [7:0]                               skip_frames,
    input  logic [$clog2(MAX_FRAMES):0]              num_frames,
    output logic                                     full,
    output logic                                     busy,
    output logic [$clog2(MAX_FRAMES*FRAME_LEN):0]    wr_count,
    input  logic [$clog2(MAX_FRAMES*FRAME_LEN)-1:0]  rd_addr,
    output logic [DATA_WID-1:0]                      rd_data,
    output logic                                     err_tlast_unexpected,
    output logic                                     err_tlast_missing
);

    localparam int   DEPTH      = MAX_FRAMES * FRAME_LEN;
    localparam int   AW         = $clog2(DEPTH);
    localparam int   NFW        = $clog2(MAX_FRAMES) + 1;
    localparam int   WCW        = AW + 1;
    localparam logic IDLE_READY = ~BACKPRESSURE;

    cap_state_t          state_r;
    logic [7:0]          skip_lat_r;
    logic [7:0]          skip_cnt_r;
    logic [NFW-1:0]      num_lat_r;
    logic [WCW-1:0]      wr_count_r;
    logic                full_r;
    logic                busy_r;
    logic                tready_r;
    logic [DATA_WID-1:0] rd_data_r;
    logic [DATA_WID-1:0] ram_r [DEPTH];

    logic                beat_s;
    logic                wr_en_s;
    logic                chk_en_s;
    logic                arm_take_s;
    logic [WCW-1:0]      last_idx_s;

    assign beat_s     = s_axis_tvalid & tready_r;
    assign wr_en_s    = beat_s && (state_r == ST_CAPTURE);
    assign chk_en_s   = beat_s && ((state_r == ST_SKIP) || (state_r == ST_CAPTURE));
    assign arm_take_s = arm && ((state_r == ST_IDLE) || (state_r == ST_FULL));
    assign last_idx_s = (WCW'(num_lat_r) * WCW'(FRAME_LEN)) - WCW'(1);

    // Capture control FSM; tready/busy/full are updated on each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            full_r     <= 1'b0;
            busy_r     <= 1'b0;
            tready_r   <= IDLE_READY;
            wr_count_r <= '0;
            skip_lat_r <= 8'd0;
            skip_cnt_r <= 8'd0;
            num_lat_r  <= NFW'(MAX_FRAMES);
        end else begin
            case (state_r)
                ST_IDLE, ST_FULL: begin
                    if (arm) begin
                        state_r    <= ST_ARMED;
                        full_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        tready_r   <= 1'b1;
                        wr_count_r <= '0;
                        skip_cnt_r <= 8'd0;
                        skip_lat_r <= skip_frames;
                        num_lat_r  <= NFW'(clamp_frames(32'(num_frames), 32'(MAX_FRAMES)));
                    end
                end
                ST_ARMED: begin
                    if (beat_s && s_axis_tlast) begin
                        if (skip_lat_r != 8'd0) begin
                            state_r <= ST_SKIP;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end
                end
                ST_SKIP: begin
                    if (beat_s && s_axis_tlast) begin
                        if (skip_cnt_r == (skip_lat_r - 8'd1)) begin
                            state_r <= ST_CAPTURE;
                        end
                        skip_cnt_r <= skip_cnt_r + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (beat_s) begin
                        wr_count_r <= wr_count_r + WCW'(1);
                        // Leaving CAPTURE on the last sample is what keeps wr_count from wrapping.
                        if (wr_count_r == last_idx_s) begin
                            state_r  <= ST_FULL;
                            full_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            tready_r <= IDLE_READY;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    full_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    tready_r <= IDLE_READY;
                end
            endcase
        end
    end

    // Sample buffer write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_r[wr_count_r[AW-1:0]] <= s_axis_tdata;
        end
    end

    // Registered readback; a same-address write in this cycle returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= ram_r[rd_addr];
        end
    end

    axis_frame_checker #(
        .FRAME_LEN (FRAME_LEN)
    ) u_checker (
        .clk                  (clk),
        .rst                  (rst),
        .clr                  (arm_take_s),
        .beat                 (chk_en_s),
        .tlast                (s_axis_tlast),
        .err_tlast_unexpected (err_tlast_unexpected),
        .err_tlast_missing    (err_tlast_missing)
    );

    assign s_axis_tready = tready_r;
    assign full          = full_r;
    assign busy          = busy_r;
    assign wr_count      = wr_count_r;
    assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture with FRAME_LEN=8, MAX_FRAMES=4.
module tb_axis_frame_capture;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] tdata;
    logic        tvalid, tlast, tready, arm;
    logic [7:0]  skip;
    logic [2:0]  num;
    logic        full, busy, eu, em;
    logic [5:0]  wr_count;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    logic [31:0] b_tdata;
    logic        b_tvalid, b_tlast, b_tready, b_arm;
    logic [7:0]  b_skip;
    logic [2:0]  b_num;
    logic        b_full, b_busy, b_eu, b_em;
    logic [5:0]  b_wr_count;
    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data;

    int checks   = 0;
    int failures = 0;
    int idx      = 0;

    always #5 clk = ~clk;

    axis_frame_capture #(.DATA_WID(32), .FRAME_LEN(8), .MAX_FRAMES(4), .BACKPRESSURE(1'b0)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .arm(arm), .skip_frames(skip), .num_frames(num), .full(full),
        .busy(busy), .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_tlast_unexpected(eu), .err_tlast_missing(em));

    axis_frame_capture #(.DATA_WID(32), .FRAME_LEN(8), .MAX_FRAMES(4), .BACKPRESSURE(1'b1)) dut_bp (
        .clk(clk), .rst(rst), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
        .s_axis_tready(b_tready), .arm(b_arm), .skip_frames(b_skip), .num_frames(b_num), .full(b_full),
        .busy(b_busy), .wr_count(b_wr_count), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .err_tlast_unexpected(b_eu), .err_tlast_missing(b_em));

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; arm = 1'b0; tdata = 32'd0; rd_addr = 5'd0;
        b_tvalid = 1'b0; b_tlast = 1'b0; b_arm = 1'b0; b_tdata = 32'd0; b_rd_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idx = 0;
    endtask

    // Source with tvalid held high: tdata = running index, tlast on every 8th beat.
    task automatic stream(input int n, input int arm_at, input int extra_at, input int miss_at);
        for (int k = 0; k < n; k++) begin
            tdata  = 32'(idx);
            tvalid = 1'b1;
            tlast  = (((idx % 8) == 7) && (idx != miss_at)) || (idx == extra_at);
            arm    = (idx == arm_at);
            @(posedge clk);
            #1;
            idx++;
        end
        tvalid = 1'b0; tlast = 1'b0; arm = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr_count !== 6'd0) begin failures++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
        checks++; if ({eu, em} !== 2'b00) begin failures++; $display("FAIL reset_errs: got %b expected 00", {eu, em}); end
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL reset_tready: got %b expected 1", tready); end
        checks++; if (b_tready !== 1'b0) begin failures++; $display("FAIL reset_tready_bp: got %b expected 0", b_tready); end
    endtask

    task automatic test_basic();
        do_reset();
        skip = 8'd0; num = 3'd2;
        stream(22, 3, -1, -1);
        checks++; if ({full, busy} !== 2'b01) begin failures++; $display("FAIL basic_pre_full: got %b expected 01", {full, busy}); end
        checks++; if (wr_count !== 6'd14) begin failures++; $display("FAIL basic_pre_count: got %0d expected 14", wr_count); end
        stream(2, -1, -1, -1);
        checks++; if ({full, busy} !== 2'b10) begin failures++; $display("FAIL basic_full: got %b expected 10", {full, busy}); end
        checks++; if (wr_count !== 6'd16) begin failures++; $display("FAIL basic_count: got %0d expected 16", wr_count); end
        checks++; if ({eu, em} !== 2'b00) begin failures++; $display("FAIL basic_errs: got %b expected 00", {eu, em}); end
        stream(4, -1, -1, -1);
        checks++; if (wr_count !== 6'd16) begin failures++; $display("FAIL basic_saturate: got %0d expected 16", wr_count); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 5'(a);
            @(posedge clk); #1;
            checks++; if (rd_data !== 32'(8 + a)) begin failures++; $display("FAIL basic_ram[%0d]: got %0d expected %0d", a, rd_data, 8 + a); end
        end
    endtask

    task automatic test_skip();
        do_reset();
        skip = 8'd2; num = 3'd1;
        stream(32, 3, -1, -1);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL skip_full: got %b expected 1", full); end
        checks++; if (wr_count !== 6'd8) begin failures++; $display("FAIL skip_count: got %0d expected 8", wr_count); end
        checks++; if ({eu, em} !== 2'b00) begin failures++; $display("FAIL skip_errs: got %b expected 00", {eu, em}); end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 5'(a);
            @(posedge clk); #1;
            checks++; if (rd_data !== 32'(24 + a)) begin failures++; $display("FAIL skip_ram[%0d]: got %0d expected %0d", a, rd_data, 24 + a); end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        skip = 8'd0; num = 3'd0;
        stream(4, 3, -1, -1);
        checks++; if ({full, busy} !== 2'b01) begin failures++; $display("FAIL clamp_armed: got %b expected 01", {full, busy}); end
        stream(36, -1, -1, -1);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL clamp0_full: got %b expected 1", full); end
        checks++; if (wr_count !== 6'd32) begin failures++; $display("FAIL clamp0_count: got %0d expected 32", wr_count); end
        rd_addr = 5'd31; @(posedge clk); #1;
        checks++; if (rd_data !== 32'd39) begin failures++; $display("FAIL clamp0_ram31: got %0d expected 39", rd_data); end
        num = 3'd7;
        stream(1, 40, -1, -1);
        checks++; if ({full, busy} !== 2'b01) begin failures++; $display("FAIL rearm_flags: got %b expected 01", {full, busy}); end
        checks++; if (wr_count !== 6'd0) begin failures++; $display("FAIL rearm_count: got %0d expected 0", wr_count); end
        stream(39, -1, -1, -1);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL clamp7_full: got %b expected 1", full); end
        checks++; if (wr_count !== 6'd32) begin failures++; $display("FAIL clamp7_count: got %0d expected 32", wr_count); end
        rd_addr = 5'd0; @(posedge clk); #1;
        checks++; if (rd_data !== 32'd48) begin failures++; $display("FAIL clamp7_ram0: got %0d expected 48", rd_data); end
        rd_addr = 5'd31; @(posedge clk); #1;
        checks++; if (rd_data !== 32'd79) begin failures++; $display("FAIL clamp7_ram31: got %0d expected 79", rd_data); end
    endtask

    task automatic test_framing();
        do_reset();
        skip = 8'd0; num = 3'd2;
        stream(24, 3, 12, -1);
        checks++; if (eu !== 1'b1) begin failures++; $display("FAIL unexp_flag: got %b expected 1", eu); end
        checks++; if ({full, wr_count} !== {1'b1, 6'd16}) begin failures++; $display("FAIL unexp_complete: got full=%b count=%0d expected full=1 count=16", full, wr_count); end
        stream(1, 24, -1, -1);
        checks++; if ({eu, em} !== 2'b00) begin failures++; $display("FAIL arm_clears_errs: got %b expected 00", {eu, em}); end
        do_reset();
        stream(24, 3, -1, 15);
        checks++; if ({eu, em} !== 2'b01) begin failures++; $display("FAIL missing_flags: got %b expected 01", {eu, em}); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL missing_full: got %b expected 1", full); end
    endtask

    task automatic test_arm_on_last();
        do_reset();
        skip = 8'd0; num = 3'd1;
        stream(15, 3, -1, -1);
        stream(1, 15, -1, -1);
        checks++; if ({full, busy} !== 2'b10) begin failures++; $display("FAIL armlast_full: got %b expected 10", {full, busy}); end
        checks++; if (wr_count !== 6'd8) begin failures++; $display("FAIL armlast_count: got %0d expected 8", wr_count); end
        stream(4, -1, -1, -1);
        checks++; if ({full, busy} !== 2'b10) begin failures++; $display("FAIL armlast_dropped: got %b expected 10", {full, busy}); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        skip = 8'd0; num = 3'd1;
        stream(13, 3, -1, -1);
        checks++; if (wr_count !== 6'd5) begin failures++; $display("FAIL rstmid_pre: got %0d expected 5", wr_count); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({full, busy, wr_count} !== 8'd0) begin failures++; $display("FAIL rstmid_abort: got full=%b busy=%b count=%0d expected all 0", full, busy, wr_count); end
        stream(11, 13, -1, -1);
        checks++; if ({full, wr_count} !== {1'b1, 6'd8}) begin failures++; $display("FAIL rstmid_recap: got full=%b count=%0d expected full=1 count=8", full, wr_count); end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 5'(a);
            @(posedge clk); #1;
            checks++; if (rd_data !== 32'(16 + a)) begin failures++; $display("FAIL rstmid_ram[%0d]: got %0d expected %0d", a, rd_data, 16 + a); end
        end
    endtask

    task automatic test_backpressure();
        int   bidx;
        int   cyc;
        logic will;
        do_reset();
        b_skip = 8'd0; b_num = 3'd1;
        b_tvalid = 1'b1;
        @(posedge clk); #1;
        checks++; if (b_tready !== 1'b0) begin failures++; $display("FAIL bp_idle_tready: got %b expected 0", b_tready); end
        b_tvalid = 1'b0; b_arm = 1'b1;
        @(posedge clk); #1;
        b_arm = 1'b0;
        checks++; if ({b_tready, b_busy} !== 2'b11) begin failures++; $display("FAIL bp_armed: got %b expected 11", {b_tready, b_busy}); end
        bidx = 0; cyc = 0;
        while (!b_full && cyc < 400) begin
            b_tvalid = 1'($urandom_range(0, 1));
            b_tdata  = 32'(bidx);
            b_tlast  = ((bidx % 8) == 7);
            will     = b_tvalid && b_tready;
            @(posedge clk); #1;
            if (will) bidx++;
            cyc++;
        end
        b_tvalid = 1'b0; b_tlast = 1'b0;
        checks++; if (b_full !== 1'b1) begin failures++; $display("FAIL bp_timeout: full=%b after %0d cycles, expected 1", b_full, cyc); end
        checks++; if (b_tready !== 1'b0) begin failures++; $display("FAIL bp_full_tready: got %b expected 0", b_tready); end
        checks++; if (b_wr_count !== 6'd8) begin failures++; $display("FAIL bp_count: got %0d expected 8", b_wr_count); end
        checks++; if (bidx !== 16) begin failures++; $display("FAIL bp_beats: got %0d expected 16", bidx); end
        for (int a = 0; a < 8; a++) begin
            b_rd_addr = 5'(a);
            @(posedge clk); #1;
            checks++; if (b_rd_data !== 32'(8 + a)) begin failures++; $display("FAIL bp_ram[%0d]: got %0d expected %0d", a, b_rd_data, 8 + a); end
        end
    endtask

    initial begin
        skip = 8'd0; num = 3'd0; b_skip = 8'd0; b_num = 3'd0;
        test_reset();
        test_basic();
        test_skip();
        test_clamp();
        test_framing();
        test_arm_on_last();
        test_rst_mid();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
